// File: rtl/serializador_oled_pkg.sv
// Shared types and constants for the SSD1306 OLED serializer.
// Optional build macro: OLED_INVERT_EN (send every pixel byte bitwise inverted).
package oled_pkg;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    INIT,
    HDR,
    DATA
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SHIFT,
    TX_GAP
  } tx_phase_t;

  localparam int INIT_LEN    = 25;
  localparam int HDR_LEN     = 6;
  localparam int FRAME_BYTES = 1024;

  // Panel bring-up: display off, clocking, mux, offset, charge pump,
  // horizontal addressing, remap, COM config, contrast, precharge, VCOMH, on.
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
    8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
  };

  // Column window 0..127, page window 0..7 before every frame.
  localparam logic [7:0] HDR_ROM [HDR_LEN] = '{
    8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07
  };

  // Pixel byte as it goes on the wire; command bytes never pass through here.
  function automatic logic [7:0] wire_data_byte(input logic [7:0] b);
`ifdef OLED_INVERT_EN
    return ~b;
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/serializador_oled_if.sv
// 4-wire SPI pins plus panel reset towards the SSD1306.
// Handshake: none on this bus; the master drives every line, the panel only listens.
interface serializador_oled_if;
  logic io_sclk;
  logic io_sdin;
  logic io_cs;
  logic io_dc;
  logic io_reset;

  modport master (
    output io_sclk,
    output io_sdin,
    output io_cs,
    output io_dc,
    output io_reset
  );

  modport slave (
    input io_sclk,
    input io_sdin,
    input io_cs,
    input io_dc,
    input io_reset
  );
endinterface

// File: rtl/serializador_oled_transmissor_spi_byte.sv
// One-byte SPI mode-0 transmitter, MSB first, with a chip-select gap after
// every byte. start/tx_byte/dc are sampled when the unit is free: idle, or in
// the final gap cycle (done high), so back-to-back bytes keep an exact gap.
module transmissor_spi_byte
  import oled_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       dc,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       sdin,
  output logic       cs,
  output logic       spi_dc
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  tx_phase_t     phase;
  logic [DW-1:0] div_cnt;
  logic [GW-1:0] gap_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;

  logic div_last;
  logic gap_last;

  assign div_last = (div_cnt == DW'(CLK_DIV - 1));
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign busy     = (phase != TX_IDLE);
  assign done     = (phase == TX_GAP) && gap_last;

  // Byte engine: divider, bit counter and cs gap, all pins registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= TX_IDLE;
      div_cnt <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      sdin    <= 1'b0;
      cs      <= 1'b1;
      spi_dc  <= 1'b0;
    end else begin
      case (phase)
        TX_IDLE: begin
          if (start) begin
            phase   <= TX_SHIFT;
            cs      <= 1'b0;
            sclk    <= 1'b0;
            sdin    <= tx_byte[7];
            shreg   <= tx_byte;
            spi_dc  <= dc;
            bit_cnt <= 3'd7;
            div_cnt <= '0;
          end
        end
        TX_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == 3'd0) begin
                cs      <= 1'b1;
                sdin    <= 1'b0;
                phase   <= TX_GAP;
                gap_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
                sdin    <= shreg[bit_cnt - 3'd1];
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        TX_GAP: begin
          if (gap_last) begin
            if (start) begin
              phase   <= TX_SHIFT;
              cs      <= 1'b0;
              sclk    <= 1'b0;
              sdin    <= tx_byte[7];
              shreg   <= tx_byte;
              spi_dc  <= dc;
              bit_cnt <= 3'd7;
              div_cnt <= '0;
            end else begin
              phase <= TX_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: phase <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serializador_oled.sv
// SSD1306 128x64 frame streamer: panel reset pulse, init commands, then an
// endless loop of address header + 1024 pixel bytes from a per-frame latch.
// Optional build macro: OLED_INVERT_EN (pixel bytes sent inverted).
module serializador_oled
  import oled_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 50000,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [8*FRAME_BYTES-1:0] image,
  serializador_oled_if.master      spi,
  output logic                     frame_done,
  output state_t                   dbg_state
);

  localparam int RW = $clog2(RESET_CYCLES + 1);

  state_t                   state;
  logic [RW-1:0]            cnt;
  logic [4:0]               rom_idx;
  logic [9:0]               byte_idx;
  logic                     sent_last;
  logic                     panel_reset;
  logic [8*FRAME_BYTES-1:0] frame_q;

  logic       cnt_last;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_dc;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_free;

  assign cnt_last     = (cnt == RW'(RESET_CYCLES - 1));
  assign tx_free      = !tx_busy || tx_done;
  assign dbg_state    = state;
  assign spi.io_reset = panel_reset;

  // Pick the next byte to launch; the last wait cycle launches init byte 0
  // so the first cs fall lands exactly RESET_CYCLES after the panel reset rises.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    tx_dc    = 1'b0;
    case (state)
      RST_WAIT: begin
        tx_start = cnt_last;
        tx_byte  = INIT_ROM[0];
      end
      INIT: begin
        tx_start = tx_free && !sent_last;
        tx_byte  = INIT_ROM[rom_idx];
      end
      HDR: begin
        tx_start = tx_free && !sent_last;
        tx_byte  = HDR_ROM[rom_idx[2:0]];
      end
      DATA: begin
        tx_start = tx_free && !sent_last;
        tx_byte  = wire_data_byte(frame_q[{byte_idx, 3'b000} +: 8]);
        tx_dc    = 1'b1;
      end
      default: ;
    endcase
  end

  // Sequencer: reset timing, ROM/byte indices, frame latch and frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_LOW;
      cnt         <= '0;
      rom_idx     <= '0;
      byte_idx    <= '0;
      sent_last   <= 1'b0;
      panel_reset <= 1'b0;
      frame_done  <= 1'b0;
      frame_q     <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        RST_LOW: begin
          if (cnt_last) begin
            state       <= RST_WAIT;
            cnt         <= '0;
            panel_reset <= 1'b1;
          end else begin
            cnt <= cnt + RW'(1);
          end
        end
        RST_WAIT: begin
          if (cnt_last) begin
            state   <= INIT;
            cnt     <= '0;
            rom_idx <= 5'd1;
          end else begin
            cnt <= cnt + RW'(1);
          end
        end
        INIT: begin
          if (sent_last) begin
            if (tx_done) begin
              state     <= HDR;
              rom_idx   <= '0;
              sent_last <= 1'b0;
              frame_q   <= image;
            end
          end else if (tx_start) begin
            rom_idx <= rom_idx + 5'd1;
            if (rom_idx == 5'(INIT_LEN - 1)) sent_last <= 1'b1;
          end
        end
        HDR: begin
          if (sent_last) begin
            if (tx_done) begin
              state     <= DATA;
              byte_idx  <= '0;
              sent_last <= 1'b0;
            end
          end else if (tx_start) begin
            rom_idx <= rom_idx + 5'd1;
            if (rom_idx == 5'(HDR_LEN - 1)) sent_last <= 1'b1;
          end
        end
        DATA: begin
          if (sent_last) begin
            if (tx_done) begin
              state      <= HDR;
              rom_idx    <= '0;
              sent_last  <= 1'b0;
              frame_q    <= image;
              frame_done <= 1'b1;
            end
          end else if (tx_start) begin
            byte_idx <= byte_idx + 10'd1;
            if (byte_idx == 10'(FRAME_BYTES - 1)) sent_last <= 1'b1;
          end
        end
        default: state <= RST_LOW;
      endcase
    end
  end

  transmissor_spi_byte #(
    .CLK_DIV   (CLK_DIV),
    .GAP_CYCLES(GAP_CYCLES)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tx_start),
    .tx_byte(tx_byte),
    .dc     (tx_dc),
    .busy   (tx_busy),
    .done   (tx_done),
    .sclk   (spi.io_sclk),
    .sdin   (spi.io_sdin),
    .cs     (spi.io_cs),
    .spi_dc (spi.io_dc)
  );

endmodule
